vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator for any resolution/refresh.
- Produces hsync/vsync with configurable polarity, active-video flag, pixel coordinates, and per-pixel/per-line/per-frame strobes for downstream pixel generators (board renderer, sprite overlay).
- Internal pixel-rate prescaler from mclk; run/pause enable.
- Sits between the clock source and the colour-output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low).
- V_SYNC_POL, 0, asserted level of vsync.
- CLK_DIV, 2, mclk cycles per pixel (>=1).
- CW, 11, counter/coordinate width; H_TOTAL and V_TOTAL must be < 2^CW.

Ports:
- mclk  in  1  system clock
- clr  in  1  synchronous active-high reset
- en  in  1  1 = timing advances; 0 = freeze
- hsync  out  1  horizontal sync, polarity H_SYNC_POL
- vsync  out  1  vertical sync, polarity V_SYNC_POL
- vga_on  out  1  current position is in the active area
- pixel_x  out  CW  active-area column; 0 when vga_on=0
- pixel_y  out  CW  active-area row; 0 when vga_on=0
- pix_tick  out  1  one-mclk pulse: outputs present a new pixel position
- line_start  out  1  pix_tick at h=0
- frame_start  out  1  pix_tick at h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Per-line order: active [0, H_ACTIVE-1], front porch, sync, back porch. Vertical order is the same, in lines.
- Prescaler div_cnt runs 0..CLK_DIV-1 while en=1. Internal tick = en && div_cnt==CLK_DIV-1. With CLK_DIV=1, tick = en.
- h_cnt increments on tick and wraps H_TOTAL-1 -> 0.
- v_cnt increments on tick only when h_cnt==H_TOTAL-1, and wraps V_TOTAL-1 -> 0. Both counters wrap on the same tick at (H_TOTAL-1, V_TOTAL-1).
- All outputs are registered every mclk from the counter values. Latency is exactly 1 mclk after a counter change, and all outputs stay mutually aligned.
- hsync = H_SYNC_POL when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise ~H_SYNC_POL. vsync follows the same rule on v.
- vga_on = (h<H_ACTIVE)&&(v<V_ACTIVE). pixel_x=h and pixel_y=v when on; both 0 otherwise. No subtraction is needed because active starts at 0.
- pix_tick is high for one mclk in the first cycle the outputs show a new position, i.e. tick delayed 2 mclk. line_start and frame_start are qualified copies of it.
- en=0: div_cnt and the counters hold, outputs hold their values, strobes are 0.
- When en returns to 1, the prescaler resumes from its held value. No pixel is skipped or repeated.
- clr (synchronous, overrides en):
  - div_cnt, h_cnt and v_cnt go to 0.
  - Outputs: hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, vga_on=0, pixel_x=pixel_y=0, strobes 0.
  - A pending flag is set.
- On the first mclk after clr deasserts, the outputs present (0,0) with pix_tick=line_start=frame_start=1, consuming the pending flag. This happens regardless of en.
- clr mid-frame aborts the frame immediately. No partial-frame state survives.
- Implementation checks CLK_DIV>=1 and totals < 2^CW at elaboration and errors otherwise.

Test Plan:
- Reset (defaults): clr high 3 cycles -> hsync=1, vsync=1, vga_on=0, pixel 0, strobes 0. First cycle after release -> vga_on=1, pixel (0,0), pix_tick=line_start=frame_start=1.
- Horizontal: hsync low for exactly 192 mclk, starting 1312 mclk after line_start. line_start period is 1600 mclk. pix_tick period is 2 mclk.
- Vertical: vsync low for 3200 mclk, beginning at the line_start of v=490. frame_start period is 840000 mclk, exactly one pulse per frame.
- Active area: per line, vga_on is high for 1280 mclk, with pixel_x stepping 0..639 (each value held 2 mclk) on rows 0..479. At h=640 and on rows 480..524: vga_on=0, pixel_x=pixel_y=0.
- Pause: en low for 50 mclk at h=300, v=10 -> all outputs constant, no strobes. After en=1, pixel_x goes to 301 with timing continuous.
- Reset/variants:
  - clr pulsed at v=200 -> next cycle shows reset values, then (0,0) with frame_start.
  - Rerun with CLK_DIV=1 and H_SYNC_POL=V_SYNC_POL=1 -> hsync high for 96 mclk, line period 800 mclk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A prescaler divides mclk down to
// the pixel rate; horizontal and vertical counters walk the raster in the
// order active -> front porch -> sync -> back porch. Every output is
// registered from the counter values, so all outputs are mutually aligned and
// lag a counter change by exactly one mclk.
//
// Ports
//   mclk        in   system clock
//   clr         in   synchronous active-high reset (overrides en)
//   en          in   1 = timing advances, 0 = everything freezes
//   hsync       out  horizontal sync, asserted level H_SYNC_POL
//   vsync       out  vertical sync, asserted level V_SYNC_POL
//   vga_on      out  current position lies in the active area
//   pixel_x     out  active-area column (0 outside the active area)
//   pixel_y     out  active-area row    (0 outside the active area)
//   pix_tick    out  one-mclk pulse: outputs show a new pixel position
//   line_start  out  pix_tick at h = 0
//   frame_start out  pix_tick at h = 0, v = 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 2,
  parameter int CW         = 11
) (
  input  logic          mclk,
  input  logic          clr,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          vga_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-bit divider register is kept even for CLK_DIV = 1; it simply
  // stays at zero so the tick reduces to en.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HPOL = (H_SYNC_POL != 0);
  localparam logic VPOL = (V_SYNC_POL != 0);

  // Elaboration-time sanity checks on the geometry.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL >= (1 << CW)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  // Counter state
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          tick;
  // tick_q: the counters moved on the previous edge, so the outputs loaded
  // on this edge show a new position.
  logic          tick_q;
  // pend_q: set by clr so that the first cycle after release announces
  // (0,0) as a fresh frame even if en is low.
  logic          pend_q;

  // Output registers and their next values
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          vga_on_q, vga_on_d;
  logic [CW-1:0] pixel_x_q, pixel_x_d;
  logic [CW-1:0] pixel_y_q, pixel_y_d;
  logic          pix_tick_q, pix_tick_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Prescaler and raster counters
  always_comb begin
    tick  = en && (div_q == DIV_LAST);
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;

    if (en) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Output decode from the current counter values
  always_comb begin
    vga_on_d      = (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d       = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HPOL : ~HPOL;
    vsync_d       = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VPOL : ~VPOL;
    pixel_x_d     = vga_on_d ? h_q : '0;
    pixel_y_d     = vga_on_d ? v_q : '0;
    pix_tick_d    = tick_q || pend_q;
    line_start_d  = pend_q || (tick_q && (h_q == '0));
    frame_start_d = pend_q || (tick_q && (h_q == '0) && (v_q == '0));
  end

  always_ff @(posedge mclk) begin
    if (clr) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      tick_q        <= 1'b0;
      pend_q        <= 1'b1;
      hsync_q       <= ~HPOL;
      vsync_q       <= ~VPOL;
      vga_on_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      tick_q        <= tick;
      pend_q        <= 1'b0;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vga_on_q      <= vga_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_on      = vga_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock:
//   dut_a : default 640x480 timing, CLK_DIV = 2, active-low syncs.
//   dut_b : 640-wide lines with a short 12-line frame, CLK_DIV = 1,
//           active-high syncs, so whole frames fit in a short run.
// Inputs are driven and outputs sampled on the falling edge. Expected output
// vectors are pushed to exp_q and popped when the matching sample is taken.
// Vector layout: {hsync, vsync, vga_on, pix_tick, line_start, frame_start,
//                 pixel_x[10:0], pixel_y[10:0]}.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Clock / reset block
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic clr_a, en_a, clr_b, en_b;

  logic        hsync_a, vsync_a, vga_on_a, pix_tick_a, line_start_a, frame_start_a;
  logic [10:0] pixel_x_a, pixel_y_a;
  logic        hsync_b, vsync_b, vga_on_b, pix_tick_b, line_start_b, frame_start_b;
  logic [10:0] pixel_x_b, pixel_y_b;

  vga_timing_gen dut_a (
    .mclk        (mclk),
    .clr         (clr_a),
    .en          (en_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .vga_on      (vga_on_a),
    .pixel_x     (pixel_x_a),
    .pixel_y     (pixel_y_a),
    .pix_tick    (pix_tick_a),
    .line_start  (line_start_a),
    .frame_start (frame_start_a)
  );

  vga_timing_gen #(
    .V_ACTIVE   (6),
    .V_FP       (2),
    .V_SYNC     (2),
    .V_BP       (2),
    .H_SYNC_POL (1),
    .V_SYNC_POL (1),
    .CLK_DIV    (1)
  ) dut_b (
    .mclk        (mclk),
    .clr         (clr_b),
    .en          (en_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .vga_on      (vga_on_b),
    .pixel_x     (pixel_x_b),
    .pixel_y     (pixel_y_b),
    .pix_tick    (pix_tick_b),
    .line_start  (line_start_b),
    .frame_start (frame_start_b)
  );

  logic [27:0] act_a, act_b;
  assign act_a = {hsync_a, vsync_a, vga_on_a, pix_tick_a, line_start_a, frame_start_a,
                  pixel_x_a, pixel_y_a};
  assign act_b = {hsync_b, vsync_b, vga_on_b, pix_tick_b, line_start_b, frame_start_b,
                  pixel_x_b, pixel_y_b};

  // Scoreboard
  logic [27:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  function automatic logic [27:0] vec(input logic hs, input logic vs, input logic on,
                                      input logic pt, input logic ls, input logic fs,
                                      input int px, input int py);
    return {hs, vs, on, pt, ls, fs, 11'(px), 11'(py)};
  endfunction

  task automatic push_exp(input logic [27:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [27:0] act);
    logic [27:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s k=%0d: no expected value queued, actual %h", nm, k, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s k=%0d: actual hs/vs/on/pt/ls/fs=%b x=%0d y=%0d, expected hs/vs/on/pt/ls/fs=%b x=%0d y=%0d",
               nm, k, act[27:22], act[21:11], act[10:0], e[27:22], e[21:11], e[10:0]);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int e);
    n_checks++;
    if (act != e) begin
      n_fail++;
      $display("FAIL %s k=%0d: actual %0d, expected %0d", nm, k, act, e);
    end
  endtask

  // Driver: advance one clock, sample point is the falling edge.
  task automatic step();
    @(negedge mclk);
    k++;
  endtask

  // Reference for dut_b from the raster index: one position per mclk.
  function automatic logic [27:0] model_b(input int idx);
    int h, v;
    logic on;
    h  = idx % 800;
    v  = (idx / 800) % 12;
    on = (h < 640) && (v < 6);
    return vec((h >= 656) && (h < 752), (v >= 8) && (v < 10), on, 1'b1,
               h == 0, (h == 0) && (v == 0), on ? h : 0, on ? v : 0);
  endfunction

  typedef struct {
    int   k;
    logic hs, vs, on, pt, ls, fs;
    int   px, py;
  } vec_t;

  vec_t tab_a[18];

  initial begin
    int last_ls, hs_high, fs_count;

    // Checkpoints for dut_a; k counts mclk samples from clr release.
    // Position index = k/2, pix_tick on even k.
    tab_a[0]  = '{0,     1, 1, 1, 1, 1, 1, 0,   0};
    tab_a[1]  = '{1,     1, 1, 1, 0, 0, 0, 0,   0};
    tab_a[2]  = '{2,     1, 1, 1, 1, 0, 0, 1,   0};
    tab_a[3]  = '{3,     1, 1, 1, 0, 0, 0, 1,   0};
    tab_a[4]  = '{1278,  1, 1, 1, 1, 0, 0, 639, 0};
    tab_a[5]  = '{1279,  1, 1, 1, 0, 0, 0, 639, 0};
    tab_a[6]  = '{1280,  1, 1, 0, 1, 0, 0, 0,   0};
    tab_a[7]  = '{1311,  1, 1, 0, 0, 0, 0, 0,   0};
    tab_a[8]  = '{1312,  0, 1, 0, 1, 0, 0, 0,   0};
    tab_a[9]  = '{1503,  0, 1, 0, 0, 0, 0, 0,   0};
    tab_a[10] = '{1504,  1, 1, 0, 1, 0, 0, 0,   0};
    tab_a[11] = '{1599,  1, 1, 0, 0, 0, 0, 0,   0};
    tab_a[12] = '{1600,  1, 1, 1, 1, 1, 0, 0,   1};
    tab_a[13] = '{1601,  1, 1, 1, 0, 0, 0, 0,   1};
    tab_a[14] = '{1612,  1, 1, 1, 1, 0, 0, 6,   1};
    tab_a[15] = '{3400,  1, 1, 1, 1, 0, 0, 100, 2};
    tab_a[16] = '{16598, 1, 1, 1, 1, 0, 0, 299, 10};
    tab_a[17] = '{16600, 1, 1, 1, 1, 0, 0, 300, 10};

    clr_a = 1'b1; en_a = 1'b1;
    clr_b = 1'b1; en_b = 1'b1;

    // Reset values held over three clr cycles
    for (int i = 0; i < 3; i++) begin
      step();
      push_exp(vec(1, 1, 0, 0, 0, 0, 0, 0));
      check("reset_a", act_a);
    end

    // Release dut_a; first sample shows (0,0) with all strobes
    clr_a = 1'b0;
    step();
    k = 0;
    foreach (tab_a[i]) begin
      while (k < tab_a[i].k) step();
      push_exp(vec(tab_a[i].hs, tab_a[i].vs, tab_a[i].on, tab_a[i].pt,
                   tab_a[i].ls, tab_a[i].fs, tab_a[i].px, tab_a[i].py));
      check("table_a", act_a);
    end

    // Pause at h=300, v=10 for 50 mclk
    en_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      push_exp(vec(1, 1, 1, 0, 0, 0, 300, 10));
      check("pause_a", act_a);
    end
    en_a = 1'b1;
    step();
    push_exp(vec(1, 1, 1, 0, 0, 0, 300, 10)); check("resume_a", act_a);
    step();
    push_exp(vec(1, 1, 1, 1, 0, 0, 301, 10)); check("resume_a", act_a);
    step();
    push_exp(vec(1, 1, 1, 0, 0, 0, 301, 10)); check("resume_a", act_a);
    step();
    push_exp(vec(1, 1, 1, 1, 0, 0, 302, 10)); check("resume_a", act_a);

    // clr mid-frame aborts the frame
    clr_a = 1'b1;
    step();
    push_exp(vec(1, 1, 0, 0, 0, 0, 0, 0)); check("midclr_a", act_a);
    clr_a = 1'b0;
    step();
    push_exp(vec(1, 1, 1, 1, 1, 1, 0, 0)); check("midclr_a", act_a);
    step();
    push_exp(vec(1, 1, 1, 0, 0, 0, 0, 0)); check("midclr_a", act_a);
    step();
    push_exp(vec(1, 1, 1, 1, 0, 0, 1, 0)); check("midclr_a", act_a);

    // dut_b: reset values with active-high syncs
    push_exp(vec(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_b", act_b);

    // dut_b: more than one full frame, compared every mclk
    clr_b = 1'b0;
    step();
    k = 0;
    last_ls  = -1;
    hs_high  = 0;
    fs_count = 0;
    while (k <= 10400) begin
      push_exp(model_b(k));
      check("frame_b", act_b);
      if (k < 800 && hsync_b) hs_high++;
      if (k < 9600 && frame_start_b) fs_count++;
      if (line_start_b) begin
        if (last_ls >= 0) check_int("line_period_b", k - last_ls, 800);
        last_ls = k;
      end
      step();
    end
    check_int("hsync_width_b", hs_high, 96);
    check_int("frame_starts_b", fs_count, 1);

    // dut_b: clr with en low still announces (0,0) once, then holds
    en_b  = 1'b0;
    clr_b = 1'b1;
    step();
    push_exp(vec(0, 0, 0, 0, 0, 0, 0, 0)); check("clr_en0_b", act_b);
    clr_b = 1'b0;
    step();
    push_exp(vec(0, 0, 1, 1, 1, 1, 0, 0)); check("clr_en0_b", act_b);
    step();
    push_exp(vec(0, 0, 1, 0, 0, 0, 0, 0)); check("clr_en0_b", act_b);
    step();
    push_exp(vec(0, 0, 1, 0, 0, 0, 0, 0)); check("clr_en0_b", act_b);
    en_b = 1'b1;
    step();
    push_exp(vec(0, 0, 1, 0, 0, 0, 0, 0)); check("clr_en0_b", act_b);
    step();
    push_exp(vec(0, 0, 1, 1, 0, 0, 1, 0)); check("clr_en0_b", act_b);
    step();
    push_exp(vec(0, 0, 1, 1, 0, 0, 2, 0)); check("clr_en0_b", act_b);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
